// File: rtl/lfsr_ctrl_pkg.sv
// lfsr_ctrl_pkg: run FSM states and expected-result helpers for lfsr_run_ctrl
package lfsr_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, DONE} run_state_t;
  function automatic int unsigned exp_period(int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction
  function automatic int unsigned exp_ones(int unsigned n);
    return 32'd1 << (n - 32'd1);
  endfunction
endpackage

// File: rtl/lfsr_run_ctrl_phase_timer.sv
// phase_timer: loadable down-counter with zero flag, shared by the CLEAR and SETTLE phases
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/lfsr_run_ctrl.sv
// lfsr_run_ctrl: LFSR period/ones characterisation sequencer; LFSR_RUN_CTRL_STATS_EN adds run/fail counters
module lfsr_run_ctrl import lfsr_ctrl_pkg::*; #(
  parameter int N             = 19,
  parameter int CLR_CYCLES    = 10,
  parameter int TICK_LAT      = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = (1 << N) + 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       max_tick,
  input  logic [N:0] ones_count,
  output logic       sh_en,
  output logic       clr_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       err_timeout,
  output logic [N:0] period_q,
  output logic [N:0] ones_q
`ifdef LFSR_RUN_CTRL_STATS_EN
  ,
  output logic [7:0] runs_q,
  output logic [7:0] fails_q
`endif
);
  localparam int PW = $clog2((CLR_CYCLES > SETTLE_CYCLES ? CLR_CYCLES : SETTLE_CYCLES) + 1);
  localparam logic [N:0] TO    = (N+1)'(TIMEOUT);
  localparam logic [N:0] EXP_P = (N+1)'(exp_period(N) + TICK_LAT);
  localparam logic [N:0] EXP_O = (N+1)'(exp_ones(N));
  run_state_t state_q, state_d;
  logic [N:0] cyc_q;
  logic [PW-1:0] ld_val;
  logic ld, tmr_zero, accept, sh_en_q, clr_q, pass_q, err_q;
  phase_timer #(.W(PW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ld),
    .val_i  (ld_val),
    .zero_o (tmr_zero)
  );
  always_comb begin
    state_d = state_q;
    ld = 1'b0;
    ld_val = PW'(CLR_CYCLES - 1);
    case (state_q)
      IDLE: if (start) begin state_d = CLEAR; ld = 1'b1; end
      CLEAR: if (tmr_zero) state_d = RUN;
      RUN:
        if (max_tick) begin
          state_d = SETTLE;
          ld = 1'b1;
          ld_val = PW'(SETTLE_CYCLES - 1);
        end else if (cyc_q == TO) state_d = DONE;
      SETTLE: if (tmr_zero) state_d = DONE;
      DONE: begin state_d = start ? CLEAR : IDLE; ld = start; end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      ld = 1'b0;
    end
  end
  assign accept = ld && state_d == CLEAR;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_en_q  <= 1'b0;
      clr_q    <= 1'b0;
      cyc_q    <= '0;
      pass_q   <= 1'b0;
      err_q    <= 1'b0;
      period_q <= '0;
      ones_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_en_q <= state_d == RUN;
      clr_q   <= state_d == CLEAR;
      cyc_q   <= (state_d == RUN && state_q != RUN) ? (N+1)'(1)
               : (state_q == RUN && cyc_q != TO) ? cyc_q + 1'b1 : cyc_q;
      if (accept) begin
        pass_q   <= 1'b0;
        err_q    <= 1'b0;
        period_q <= '0;
        ones_q   <= '0;
      end
      if (state_q == RUN && state_d == SETTLE) period_q <= cyc_q;
      if (state_q == RUN && state_d == DONE) err_q <= 1'b1;
      // pass is resolved on entry to DONE so it is valid alongside the done pulse
      if (state_q == SETTLE && state_d == DONE) begin
        ones_q <= ones_count;
        pass_q <= period_q == EXP_P && ones_count == EXP_O && !err_q;
      end
    end
`ifdef LFSR_RUN_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      runs_q  <= '0;
      fails_q <= '0;
    end else if (state_q == DONE) begin
      runs_q  <= runs_q != 8'hff ? runs_q + 1'b1 : runs_q;
      fails_q <= (!pass_q && fails_q != 8'hff) ? fails_q + 1'b1 : fails_q;
    end
`endif
  assign sh_en       = sh_en_q;
  assign clr_o       = clr_q;
  assign busy        = state_q == CLEAR || state_q == RUN || state_q == SETTLE;
  assign done        = state_q == DONE;
  assign pass        = pass_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// tb_lfsr_run_ctrl: table-driven directed bench for lfsr_run_ctrl at N=8; LFSR_RUN_CTRL_STATS_EN checks counters
module tb_lfsr_run_ctrl;
  localparam int N = 8;
  logic clk, rst_n, start, abort, max_tick;
  logic [N:0] ones_count, period_q, ones_q;
  logic sh_en, clr_o, busy, done, pass, err_timeout;
`ifdef LFSR_RUN_CTRL_STATS_EN
  logic [7:0] runs_q, fails_q;
`endif
  int checks = 0;
  int errors = 0;
  int exp_runs = 0;
  int exp_fails = 0;
  lfsr_run_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .max_tick    (max_tick),
    .ones_count  (ones_count),
    .sh_en       (sh_en),
    .clr_o       (clr_o),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_timeout (err_timeout),
    .period_q    (period_q),
    .ones_q      (ones_q)
`ifdef LFSR_RUN_CTRL_STATS_EN
    ,
    .runs_q      (runs_q),
    .fails_q     (fails_q)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    int tick_at;
    int ones;
    int abort_at;
    int start_at;
    bit exp_done;
    int exp_lat;
    int exp_period;
    int exp_ones;
    bit exp_pass;
    bit exp_err;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_vec(input int tick_at, input int ones, input int abort_at, input int start_at,
                         output bit got_done, output int lat);
    int rc;
    bit ab_prev;
    rc = 0;
    ab_prev = 1'b0;
    got_done = 1'b0;
    lat = 0;
    ones_count = (N+1)'(ones);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      if (done) begin
        got_done = 1'b1;
        lat = i;
        break;
      end
      if (ab_prev) chk("abort_to_idle", {29'd0, sh_en, clr_o, busy}, 0);
      if (sh_en) rc++;
      ab_prev = sh_en && rc == abort_at;
      abort = ab_prev;
      max_tick = sh_en && rc == tick_at;
      start = sh_en && rc == start_at;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    max_tick = 1'b0;
  endtask
  initial begin
    bit gd;
    int lat, n;
    tbl[0] = '{256, 128, 0, 0, 1, 269, 256, 128, 1, 0};
    tbl[1] = '{100, 128, 0, 20, 1, 113, 100, 128, 0, 0};
    tbl[2] = '{256, 127, 0, 0, 1, 269, 256, 127, 0, 0};
    tbl[3] = '{0, 128, 0, 0, 1, 283, 0, 0, 0, 1};
    tbl[4] = '{272, 128, 0, 0, 1, 285, 272, 128, 0, 0};
    tbl[5] = '{1, 128, 0, 0, 1, 14, 1, 128, 0, 0};
    tbl[6] = '{0, 128, 50, 0, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{256, 128, 0, 0, 1, 269, 256, 128, 1, 0};
    tbl[8] = '{256, 384, 0, 0, 1, 269, 256, 384, 0, 0};
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    max_tick = 1'b0;
    ones_count = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sh_en", sh_en, 0);
    chk("rst_clr_o", clr_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_period", period_q, 0);
    chk("rst_ones", ones_q, 0);
    for (int v = 0; v < 9; v++) begin
      run_vec(tbl[v].tick_at, tbl[v].ones, tbl[v].abort_at, tbl[v].start_at, gd, lat);
      chk($sformatf("v%0d_done", v), gd, tbl[v].exp_done);
      if (gd) begin
        exp_runs++;
        if (!tbl[v].exp_pass) exp_fails++;
        chk($sformatf("v%0d_latency", v), lat, tbl[v].exp_lat);
        chk($sformatf("v%0d_sh_en_at_done", v), sh_en, 0);
      end
      chk($sformatf("v%0d_period", v), period_q, tbl[v].exp_period);
      chk($sformatf("v%0d_ones", v), ones_q, tbl[v].exp_ones);
      chk($sformatf("v%0d_pass", v), pass, tbl[v].exp_pass);
      chk($sformatf("v%0d_err", v), err_timeout, tbl[v].exp_err);
      @(negedge clk);
      chk($sformatf("v%0d_done_cleared", v), done, 0);
      chk($sformatf("v%0d_idle", v), busy, 0);
    end
    // start held in the DONE cycle chains straight into a new CLEAR phase
    run_vec(256, 128, 0, 0, gd, lat);
    chk("chain_done", gd, 1);
    chk("chain_pass", pass, 1);
    exp_runs++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("chain_clr", clr_o, 1);
    chk("chain_pass_cleared", pass, 0);
    n = 0;
    while (clr_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("chain_clr_cycles", n, 10);
    chk("chain_sh_en", sh_en, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("chain_abort_sh_en", sh_en, 0);
    // abort beats start in the DONE cycle and leaves captures intact
    run_vec(5, 0, 0, 0, gd, lat);
    chk("ab_done", gd, 1);
    chk("ab_period", period_q, 5);
    exp_runs++;
    exp_fails++;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_clr", clr_o, 0);
    chk("ab_period_kept", period_q, 5);
    @(negedge clk);
    chk("ab_still_idle", {30'd0, clr_o, busy}, 0);
`ifdef LFSR_RUN_CTRL_STATS_EN
    chk("stats_runs", runs_q, exp_runs);
    chk("stats_fails", fails_q, exp_fails);
`endif
    // asynchronous reset mid-RUN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!sh_en && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("rr_in_run", sh_en, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rr_sh_en_async", sh_en, 0);
    chk("rr_clr", clr_o, 0);
    chk("rr_busy", busy, 0);
    chk("rr_pass", pass, 0);
    chk("rr_period", period_q, 0);
    chk("rr_ones", ones_q, 0);
`ifdef LFSR_RUN_CTRL_STATS_EN
    chk("rr_runs", runs_q, 0);
    chk("rr_fails", fails_q, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rr_idle_after", {29'd0, sh_en, clr_o, busy}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lfsr_run_ctrl.md
# lfsr_run_ctrl

Sequencer for one LFSR characterisation run. On a start pulse it clears the stop-watch, enables the 19-bit LFSR for one full period and detects the period end via the LFSR's max-tick. It then freezes both blocks, captures the measured period and the stop-watch ones-count, and flags pass/fail. It sits above `lfsr_19bit` and `stop_watch_if`: it drives their `sh_en`/`go` and `rst_n`/`clr`, replacing the hand-timed enable window used in simulation.

## Interface
- `N`, 19: LFSR width; expected period 2^N-1, expected ones per period 2^(N-1).
- `CLR_CYCLES`, 10: cycles `clr_o` is held high before a run.
- `TICK_LAT`, 1: cycles between the LFSR returning to its seed and `max_tick` being visible.
- `SETTLE_CYCLES`, 2: cycles after `sh_en` falls before the stop-watch count is sampled.
- `TIMEOUT`, 2^N+16: RUN-cycle limit without a tick.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle run request.
- `abort`  in  1  cancel the current run.
- `max_tick`  in  1  period-end pulse from `lfsr_19bit`.
- `ones_count`  in  N+1  `count` output of `stop_watch_if`.
- `sh_en`  out  1  LFSR shift enable and stop-watch `go` (registered).
- `clr_o`  out  1  stop-watch clear and LFSR reset request, active high (registered).
- `busy`  out  1  high in CLEAR, RUN and SETTLE.
- `done`  out  1  one-cycle pulse when a run completes or fails.
- `pass`  out  1  result of the last run; held until the next accepted `start`.
- `err_timeout`  out  1  last run hit `TIMEOUT`.
- `period_q`  out  N+1  captured period.
- `ones_q`  out  N+1  captured ones count.

## Operation
- FSM states: IDLE, CLEAR, RUN, SETTLE, DONE.
- IDLE/DONE + `start` -> CLEAR. Clear `pass`, `err_timeout`, `period_q` and `ones_q`, and load the phase counter. `start` in CLEAR/RUN/SETTLE is ignored.
- CLEAR: `clr_o`=1, `sh_en`=0 for exactly `CLR_CYCLES` cycles -> RUN.
- RUN: `sh_en`=1. The cycle counter `cyc` (N+1 bits) is 1 in the first RUN cycle and increments each RUN cycle.
  - `max_tick` sampled high -> `period_q`<=`cyc`, go to SETTLE.
  - `cyc`==`TIMEOUT` with no tick -> `err_timeout`=1, go to DONE. A tick in that same cycle wins.
- SETTLE: `sh_en`=0 for `SETTLE_CYCLES` cycles. In the last cycle, `ones_q`<=`ones_count` -> DONE.
- DONE (one cycle): `done`=1. `pass`=1 iff `period_q`==2^N-1+`TICK_LAT` and `ones_q`==2^(N-1) and `err_timeout`=0. Next state IDLE, or CLEAR if `start` is high.
- `abort` in any state other than IDLE -> IDLE next cycle. `sh_en`=`clr_o`=0, no `done` pulse, captures keep their values. `abort` beats `start` in the same cycle.
- No arithmetic wraps: `cyc` saturates at `TIMEOUT`. `ones_count` is sampled as-is.
- Reset: state IDLE; every output 0, including `period_q`/`ones_q`. Reset asserted mid-run drops `sh_en` immediately (asynchronously).

## Timing
- `start` at edge k: `clr_o` high from k+1 through k+`CLR_CYCLES`. `sh_en` rises at k+`CLR_CYCLES`+1.
- `sh_en` falls on the edge after `max_tick` is sampled. `done` is high `SETTLE_CYCLES`+1 cycles after that edge.
- Nominal N=19 run: 10 + 524288 + 2 + 1 cycles from `start` to `done`.
- `pass`, `period_q` and `ones_q` are valid in the `done` cycle and stable until the next accepted `start`.

## Configuration
- `LFSR_RUN_CTRL_STATS_EN` defined: adds outputs `runs_q` and `fails_q` (8 bits each, saturating at 255). They increment in the DONE cycle (`fails_q` only when `pass`=0), are untouched by `abort`, and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Package `lfsr_ctrl_pkg`: state enum `run_state_t`, and functions returning the expected period and expected ones count for a given N.
- Sub-module `phase_timer`: loadable down-counter shared by CLEAR and SETTLE, with a `zero` flag. The RUN cycle counter stays in the top level.

## Test plan
- Nominal run with the real `lfsr_19bit` + `stop_watch_if`, `start` pulse -> `done` after 524301 cycles, `period_q`=524288, `ones_q`=262144, `pass`=1.
- `max_tick` tied low -> `err_timeout`=1, `done` at `cyc`=524304, `pass`=0, `sh_en` low the following cycle.
- Forced `max_tick` at `cyc`=1000 -> `period_q`=1000, `pass`=0, `err_timeout`=0.
- `abort` at RUN cycle 50 -> IDLE next cycle, `sh_en`=0, no `done`; a following `start` runs cleanly to `pass`=1.
- `start` repulsed during RUN is ignored. `start` held high in the DONE cycle re-enters CLEAR, with `clr_o` high for 10 cycles.
- `rst_n` low mid-RUN -> `sh_en`=0 without waiting for a clock edge and all outputs 0. With `LFSR_RUN_CTRL_STATS_EN`, 3 runs (2 pass, 1 forced fail) -> `runs_q`=3, `fails_q`=1.
